// File: rtl/decode_seq.sv
// decode_seq: self-sequencing instruction decoder.
// Accepts one instruction at a time, latches it, and walks a one-hot stage
// vector through N_STG stages. Decoded fields and datapath selects are derived
// only from the latched word and the stage register, so no output depends
// combinationally on inst. A memory stall freezes the whole sequence.
//
// Handshake: an instruction transfers on a rising clk edge where
// inst_valid && inst_ready. inst_ready is high while idle, and in the final
// stage when not stalled, so a new instruction can follow with no bubble.
// inst_valid is not required to stay high without inst_ready.
//
// The FSM state is fully visible on the stage output: all-zero means IDLE,
// a single set bit s means RUN(s).

module decode_seq #(
  parameter int IMM_W = 16,
  parameter int RA_W  = 4,
  parameter int N_STG = 4,
  localparam int IW   = IMM_W + 3 * RA_W + 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inst_valid,
  input  logic [IW-1:0]    inst,
  output logic             inst_ready,
  input  logic             stall,
  input  logic             dbg_req,
  output logic [N_STG-1:0] stage,
  output logic [3:0]       opc,
  output logic [RA_W-1:0]  sa1,
  output logic [RA_W-1:0]  sa2,
  output logic [RA_W-1:0]  da,
  output logic [IMM_W-1:0] imm,
  output logic [3:0]       alu_ctrl,
  output logic             pfc_ctrl,
  output logic             s2_sel,
  output logic [2:0]       din_sel,
  output logic [4:0]       addr_sel,
  output logic             retire,
  output logic             illegal
);

  // Opcode encodings
  localparam logic [3:0] OPC_CALC  = 4'b0000;
  localparam logic [3:0] OPC_CALCI = 4'b0001;
  localparam logic [3:0] OPC_LOAD  = 4'b0011;
  localparam logic [3:0] OPC_STORE = 4'b0111;
  localparam logic [3:0] OPC_CALIF = 4'b1111;

  // Register write source (one-hot)
  localparam logic [2:0] DIN_SR2 = 3'b001;
  localparam logic [2:0] DIN_ALU = 3'b010;
  localparam logic [2:0] DIN_RA  = 3'b100;

  // Memory address mux (one-hot)
  localparam logic [4:0] ADDR_NONE = 5'b00000;
  localparam logic [4:0] ADDR_ALU  = 5'b00001;
  localparam logic [4:0] ADDR_SA1  = 5'b00010;
  localparam logic [4:0] ADDR_SA2  = 5'b00100;
  localparam logic [4:0] ADDR_DA   = 5'b01000;
  localparam logic [4:0] ADDR_DBG  = 5'b10000;

  localparam logic [N_STG-1:0] STG_FIRST = {{(N_STG-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [N_STG-1:0]   stage_q, stage_d;
  logic [IW-1:0]      word_q, word_d;
  logic               illegal_q, illegal_d;

  logic               in_last;
  logic               accept;
  logic               inst_legal;

  // True for the five defined opcodes.
  function automatic logic opc_is_legal(input logic [3:0] o);
    logic ok;
    ok = 1'b0;
    case (o)
      OPC_CALC, OPC_CALCI, OPC_LOAD, OPC_STORE, OPC_CALIF: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  assign in_last    = (state_q == ST_RUN) && stage_q[N_STG-1];
  assign inst_ready = (state_q == ST_IDLE) || (in_last && !stall);
  assign retire     = in_last && !stall;
  assign accept     = inst_valid && inst_ready;
  assign inst_legal = opc_is_legal(inst[3:0]);

  // State, stage, latched word and illegal pulse registers; reset wins over all.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      stage_q   <= '0;
      word_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      stage_q   <= stage_d;
      word_q    <= word_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state: accept, advance the one-hot stage, chain or return to idle.
  always_comb begin
    state_d   = state_q;
    stage_d   = stage_q;
    word_d    = word_q;
    illegal_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (inst_legal) begin
            state_d = ST_RUN;
            stage_d = STG_FIRST;
            word_d  = inst;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (!stall) begin
          if (stage_q[N_STG-1]) begin
            if (accept && inst_legal) begin
              stage_d = STG_FIRST;
              word_d  = inst;
            end else begin
              state_d   = ST_IDLE;
              stage_d   = '0;
              illegal_d = accept;
            end
          end else begin
            stage_d = {stage_q[N_STG-2:0], 1'b0};
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        stage_d = '0;
      end
    endcase
  end

  // Latched fields, laid out as {imm, da, sa2, sa1, opc}.
  assign opc     = word_q[3:0];
  assign sa1     = word_q[4 +: RA_W];
  assign sa2     = word_q[4 + RA_W +: RA_W];
  assign da      = word_q[4 + 2 * RA_W +: RA_W];
  assign imm     = word_q[4 + 3 * RA_W +: IMM_W];
  assign stage   = stage_q;
  assign illegal = illegal_q;

  // Per-instruction decode from the latched opcode.
  always_comb begin
    alu_ctrl = 4'b0000;
    pfc_ctrl = 1'b0;
    s2_sel   = 1'b1;
    din_sel  = DIN_RA;
    case (opc)
      OPC_CALC: begin
        alu_ctrl = imm[3:0];
        s2_sel   = 1'b0;
        din_sel  = DIN_ALU;
      end
      OPC_CALCI: begin
        alu_ctrl = sa2[3:0];
        din_sel  = DIN_ALU;
      end
      OPC_LOAD, OPC_STORE: begin
        din_sel = DIN_SR2;
      end
      OPC_CALIF: begin
        pfc_ctrl = 1'b1;
      end
      default: begin
        din_sel = DIN_RA;
      end
    endcase
  end

  // Memory address select per stage; the debug slot is only offered while idle.
  always_comb begin
    addr_sel = ADDR_NONE;
    if (state_q == ST_IDLE) begin
      if (dbg_req) addr_sel = ADDR_DBG;
    end else if (stage_q[0]) begin
      addr_sel = ADDR_SA1;
    end else if (stage_q[1]) begin
      addr_sel = (opc == OPC_LOAD) ? ADDR_ALU : ADDR_SA2;
    end else if (stage_q[2]) begin
      addr_sel = (opc == OPC_STORE) ? ADDR_ALU : ADDR_DA;
    end
  end

endmodule

// File: tb/tb_decode_seq.sv
// Bench for decode_seq: directed instructions with hand-computed decode values.
// The driver pushes cycle-stamped expected observations into exp_q; the monitor
// pops and compares whenever the DUT shows a stage, an illegal pulse, or the
// driver requests a probe of an idle cycle.

module tb_decode_seq;

  localparam int IMM_W = 16;
  localparam int RA_W  = 4;
  localparam int N_STG = 4;
  localparam int IW    = 32;
  localparam int OW    = 53;
  localparam int EW    = OW + 16;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic             inst_valid;
  logic [IW-1:0]    inst;
  logic             inst_ready;
  logic             stall;
  logic             dbg_req;
  logic [N_STG-1:0] stage;
  logic [3:0]       opc;
  logic [RA_W-1:0]  sa1, sa2, da;
  logic [IMM_W-1:0] imm;
  logic [3:0]       alu_ctrl;
  logic             pfc_ctrl;
  logic             s2_sel;
  logic [2:0]       din_sel;
  logic [4:0]       addr_sel;
  logic             retire;
  logic             illegal;

  decode_seq #(.IMM_W(IMM_W), .RA_W(RA_W), .N_STG(N_STG)) dut (
    .clk(clk), .rst_n(rst_n), .inst_valid(inst_valid), .inst(inst),
    .inst_ready(inst_ready), .stall(stall), .dbg_req(dbg_req), .stage(stage),
    .opc(opc), .sa1(sa1), .sa2(sa2), .da(da), .imm(imm), .alu_ctrl(alu_ctrl),
    .pfc_ctrl(pfc_ctrl), .s2_sel(s2_sel), .din_sel(din_sel), .addr_sel(addr_sel),
    .retire(retire), .illegal(illegal)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard
  logic [EW-1:0] exp_q[$];
  int            id_q[$];
  int            n_checks = 0;
  int            n_pass   = 0;
  logic          probe;
  logic          drain_chk;

  logic [OW-1:0] act_obs;
  assign act_obs = {stage, opc, sa1, sa2, da, imm, alu_ctrl, pfc_ctrl, s2_sel,
                    din_sel, addr_sel, retire, illegal, inst_ready};

  function automatic logic [OW-1:0] mk_obs(input logic [3:0] stg, input logic [31:0] w,
                                           input logic [3:0] alu, input logic pfc,
                                           input logic s2, input logic [2:0] din,
                                           input logic [4:0] addr, input logic ret,
                                           input logic ill, input logic rdy);
    return {stg, w[3:0], w[7:4], w[11:8], w[15:12], w[31:16], alu, pfc, s2, din,
            addr, ret, ill, rdy};
  endfunction

  // monitor
  always @(negedge clk) begin
    logic [EW-1:0] e;
    logic [EW-1:0] a;
    int            id;
    if ((|stage) || illegal || probe) begin
      n_checks++;
      a = {cyc[15:0], act_obs};
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_output cyc=%0d got=%h required=nothing", cyc, a);
      end else begin
        e  = exp_q.pop_front();
        id = id_q.pop_front();
        if (a !== e) $display("FAIL obs id=%0d got=%h required=%h", id, a, e);
        else n_pass++;
      end
    end
    if (drain_chk) begin
      n_checks++;
      if (exp_q.size() != 0)
        $display("FAIL drain got=%0d pending required=0", exp_q.size());
      else n_pass++;
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int id, input int t, input logic [OW-1:0] o);
    logic [15:0] ts;
    ts = 16'(t);
    exp_q.push_back({ts, o});
    id_q.push_back(id);
  endtask

  task automatic send(input logic [31:0] w);
    inst_valid = 1'b1;
    inst       = w;
    tick(1);
    inst_valid = 1'b0;
    inst       = 32'($urandom);
  endtask

  // Expected stage sequence for one instruction accepted at the end of this cycle.
  // addrs holds the per-stage addr_sel (stage s at [5s+:5]); stl holds stall
  // cycle counts per stage (stage s at [4s+:4]); n_emit limits stages emitted.
  task automatic expect_inst(input int id, input logic [31:0] w, input logic [3:0] alu,
                             input logic pfc, input logic s2, input logic [2:0] din,
                             input logic [19:0] addrs, input logic [15:0] stl,
                             input int n_emit);
    int t;
    logic [3:0] sv;
    logic fin;
    t = cyc + 1;
    for (int s = 0; s < n_emit; s++) begin
      sv  = 4'(1 << s);
      fin = (s == N_STG - 1);
      for (int k = 0; k < int'(stl[4*s +: 4]); k++) begin
        push(id, t, mk_obs(sv, w, alu, pfc, s2, din, addrs[5*s +: 5], 1'b0, 1'b0, 1'b0));
        t++;
      end
      push(id, t, mk_obs(sv, w, alu, pfc, s2, din, addrs[5*s +: 5], fin, 1'b0, fin));
      t++;
    end
  endtask

  task automatic probe_obs(input int id, input logic [OW-1:0] o);
    push(id, cyc, o);
    probe = 1'b1;
    tick(1);
    probe = 1'b0;
  endtask

  localparam logic [31:0] W_CALC  = 32'h0005_3210;
  localparam logic [31:0] W_LOAD  = 32'h0010_3213;
  localparam logic [31:0] W_STORE = 32'h0020_3217;
  localparam logic [31:0] W_CALCI = 32'h00FF_0A21;
  localparam logic [31:0] W_BAD   = 32'h0000_0002;
  localparam logic [31:0] W_CALIF = 32'h0000_000F;

  // addr_sel sequences, stage 3 first
  localparam logic [19:0] A_PLAIN = {5'b00000, 5'b01000, 5'b00100, 5'b00010};
  localparam logic [19:0] A_LOAD  = {5'b00000, 5'b01000, 5'b00001, 5'b00010};
  localparam logic [19:0] A_STORE = {5'b00000, 5'b00001, 5'b00100, 5'b00010};

  initial begin
    rst_n      = 1'b0;
    inst_valid = 1'b0;
    inst       = '0;
    stall      = 1'b0;
    dbg_req    = 1'b0;
    probe      = 1'b0;
    drain_chk  = 1'b0;
    tick(3);
    rst_n = 1'b1;

    // reset state: word 0 decodes as CALC with all-zero fields
    probe_obs(0, mk_obs(4'b0, 32'h0, 4'h0, 1'b0, 1'b0, 3'b010, 5'b0, 1'b0, 1'b0, 1'b1));

    // CALC
    expect_inst(1, W_CALC, 4'h5, 1'b0, 1'b0, 3'b010, A_PLAIN, 16'h0, 4);
    send(W_CALC);
    tick(4);

    // LOAD then STORE back-to-back
    expect_inst(2, W_LOAD, 4'h0, 1'b0, 1'b1, 3'b001, A_LOAD, 16'h0, 4);
    send(W_LOAD);
    tick(3);
    expect_inst(3, W_STORE, 4'h0, 1'b0, 1'b1, 3'b001, A_STORE, 16'h0, 4);
    send(W_STORE);
    tick(4);

    // CALCI: 2 stall cycles in stage 0010, 1 stall cycle in the final stage
    expect_inst(4, W_CALCI, 4'hA, 1'b0, 1'b1, 3'b010, A_PLAIN, 16'h1020, 4);
    send(W_CALCI);
    tick(1);
    stall = 1'b1;
    tick(2);
    stall = 1'b0;
    tick(2);
    stall = 1'b1;
    tick(1);
    stall = 1'b0;
    tick(1);

    // illegal opcode: fields keep CALCI, one-cycle pulse, stays idle
    push(5, cyc + 1, mk_obs(4'b0, W_CALCI, 4'hA, 1'b0, 1'b1, 3'b010, 5'b0, 1'b0, 1'b1, 1'b1));
    send(W_BAD);
    tick(1);
    probe_obs(6, mk_obs(4'b0, W_CALCI, 4'hA, 1'b0, 1'b1, 3'b010, 5'b0, 1'b0, 1'b0, 1'b1));

    // CALIF
    expect_inst(7, W_CALIF, 4'h0, 1'b1, 1'b1, 3'b100, A_PLAIN, 16'h0, 4);
    send(W_CALIF);
    tick(4);

    // debug slot while idle, ignored while running
    dbg_req = 1'b1;
    probe_obs(8, mk_obs(4'b0, W_CALIF, 4'h0, 1'b1, 1'b1, 3'b100, 5'b10000, 1'b0, 1'b0, 1'b1));
    expect_inst(9, W_CALC, 4'h5, 1'b0, 1'b0, 3'b010, A_PLAIN, 16'h0, 4);
    send(W_CALC);
    tick(4);
    dbg_req = 1'b0;

    // reset during stage 0100, with an offered instruction while reset is held
    expect_inst(10, W_LOAD, 4'h0, 1'b0, 1'b1, 3'b001, A_LOAD, 16'h0, 3);
    send(W_LOAD);
    tick(2);
    rst_n = 1'b0;
    tick(1);
    inst_valid = 1'b1;
    inst       = W_CALC;
    probe_obs(11, mk_obs(4'b0, 32'h0, 4'h0, 1'b0, 1'b0, 3'b010, 5'b0, 1'b0, 1'b0, 1'b1));
    inst_valid = 1'b0;
    rst_n      = 1'b1;
    probe_obs(12, mk_obs(4'b0, 32'h0, 4'h0, 1'b0, 1'b0, 3'b010, 5'b0, 1'b0, 1'b0, 1'b1));
    tick(3);

    drain_chk = 1'b1;
    tick(1);
    drain_chk = 1'b0;
    tick(1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
